// File: rtl/rob_order_buffer_pkg.sv
// Shared constants and entry layout for the reorder buffer.
// ROB_DEPTH must be a power of two: the pointers wrap by plain binary overflow.
package rob_order_buffer_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int RAT_PS_WIDTH   = 6;
  localparam int AR_WIDTH       = 5;
  localparam int ROB_IDX_WIDTH  = $clog2(ROB_DEPTH);
  localparam int ROB_PTR_WIDTH  = ROB_IDX_WIDTH + 1;

  // One reorder-buffer slot payload: destination physical/arch pair and completion flag.
  typedef struct packed {
    logic [RAT_PS_WIDTH-1:0] pd;
    logic [AR_WIDTH-1:0]     rd;
    logic                    ready;
  } rob_entry_t;

  localparam int ROB_DATA_WIDTH = $bits(rob_entry_t);

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer: IDX bits address the slot, the MSB flips on each wrap
// so equal index bits can be told apart as empty (same wrap) or full (different wrap).
module rob_ptr
  import rob_order_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     inc_i,
  output logic [ROB_PTR_WIDTH-1:0] ptr_o
);

  logic [ROB_PTR_WIDTH-1:0] ptr_q;
  logic [ROB_PTR_WIDTH-1:0] ptr_d;

  // Next pointer: clear wins over increment; overflow of the top bit gives the wrap.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ROB_PTR_WIDTH'(1);
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_order_buffer.sv
// 16-entry in-order-retire reorder buffer between dispatch and architectural commit.
// Optional macro ROB_CDB_BYPASS_EN: a CDB writeback to the head retires it in the same cycle.
module rob_order_buffer
  import rob_order_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_valid,
  input  logic [RAT_PS_WIDTH-1:0]  dispatch_pd,
  input  logic [AR_WIDTH-1:0]      dispatch_rd,
  output logic                     dispatch_ready,
  output logic [ROB_IDX_WIDTH-1:0] dispatch_rob_idx,
  input  logic                     cdb_valid,
  input  logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  output logic                     commit_valid,
  output logic [RAT_PS_WIDTH-1:0]  commit_pd,
  output logic [AR_WIDTH-1:0]      commit_rd,
  output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
  input  logic                     flush,
  output logic                     empty
);

  logic [ROB_PTR_WIDTH-1:0]  head_ptr;
  logic [ROB_PTR_WIDTH-1:0]  tail_ptr;
  logic [ROB_IDX_WIDTH-1:0]  head_idx;
  logic [ROB_IDX_WIDTH-1:0]  tail_idx;
  logic                      full;
  logic                      head_ready;
  logic                      dispatch_fire;
  logic                      cdb_fire;
  logic [ROB_DEPTH-1:0]      valid_q;
  logic [ROB_DEPTH-1:0]      valid_d;
  logic [ROB_DATA_WIDTH-1:0] alloc_word;
  rob_entry_t                entry_q [ROB_DEPTH];
  rob_entry_t                head_entry;

  rob_ptr u_head_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .inc_i   (commit_valid),
    .ptr_o   (head_ptr)
  );

  rob_ptr u_tail_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .inc_i   (dispatch_fire),
    .ptr_o   (tail_ptr)
  );

  assign head_idx = head_ptr[ROB_IDX_WIDTH-1:0];
  assign tail_idx = tail_ptr[ROB_IDX_WIDTH-1:0];

  assign full  = (head_idx == tail_idx) &&
                 (head_ptr[ROB_PTR_WIDTH-1] != tail_ptr[ROB_PTR_WIDTH-1]);
  assign empty = (head_ptr == tail_ptr);

  // Dispatch capacity ignores a same-cycle commit so the ready path stays short.
  assign dispatch_ready   = !full;
  assign dispatch_rob_idx = tail_idx;
  assign dispatch_fire    = dispatch_valid && !full && !flush;

  // A writeback only counts for a live entry; the slot being allocated is never live.
  assign cdb_fire = cdb_valid && !flush && valid_q[cdb_rob_idx];

  assign head_entry = entry_q[head_idx];

`ifdef ROB_CDB_BYPASS_EN
  assign head_ready = head_entry.ready || (cdb_valid && (cdb_rob_idx == head_idx));
`else
  assign head_ready = head_entry.ready;
`endif

  assign commit_valid   = !empty && valid_q[head_idx] && head_ready && !flush;
  assign commit_pd      = head_entry.pd;
  assign commit_rd      = head_entry.rd;
  assign commit_rob_idx = head_idx;

  assign alloc_word = {dispatch_pd, dispatch_rd, 1'b0};

  // Valid-bit next state: flush drops everything, commit frees the head, dispatch claims the tail.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (commit_valid) begin
        valid_d[head_idx] = 1'b0;
      end
      if (dispatch_fire) begin
        valid_d[tail_idx] = 1'b1;
      end
    end
  end

  // Valid bits: the only per-entry state that must be cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload storage: writeback sets ready, allocation writes a fresh not-ready entry.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; valid_q gates every use, so stale contents are harmless.
    if (cdb_fire) begin
      entry_q[cdb_rob_idx].ready <= 1'b1;
    end
    if (dispatch_fire) begin
      entry_q[tail_idx] <= alloc_word;
    end
  end

endmodule
